// File: rtl/fft_output_reorder.sv
// Bit-reversed to natural-order reorder stage behind the 64-point DIF FFT.
// Ping-pong frame buffers with a valid/ready output stream; define FFT_REORDER_INDEX_EN to expose out_index.
module fft_output_reorder #(
    parameter int DW    = 16,
    parameter int LOG2N = 6,
    parameter int N     = 64
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              in_valid,
    input  logic              in_first,
    input  logic              bank_sel,
    input  logic [2*DW-1:0]   rdata_b0,
    input  logic [2*DW-1:0]   rdata_b1,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [2*DW-1:0]   out_data,
    output logic              out_last,
`ifdef FFT_REORDER_INDEX_EN
    output logic [LOG2N-1:0]  out_index,
`endif
    output logic              overrun,
    output logic              frame_err,
    input  logic              clr_status
);

    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;
    typedef enum logic {R_IDLE, R_DRAIN} rstate_t;

    wstate_t wstate, wstate_n;
    rstate_t rstate, rstate_n;

    logic [2*DW-1:0]  buf0 [N];
    logic [2*DW-1:0]  buf1 [N];
    logic [1:0]       full, full_n, full_set, full_clr;
    logic             wsel, wsel_n, rsel, rsel_n;
    logic [LOG2N-1:0] wcnt, wcnt_n, rcnt, rcnt_n;
    logic             overrun_n, frame_err_n;
    logic             ovr_set, ferr_set, start;
    logic             we;
    logic [LOG2N-1:0] waddr;
    logic [2*DW-1:0]  sample;
    logic             rd_last;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
        for (int i = 0; i < LOG2N; i++) bitrev[i] = k[LOG2N-1-i];
    endfunction

    assign sample = bank_sel ? rdata_b1 : rdata_b0;

    // Write side: a frame start is checked against full[] as registered, so a
    // buffer freed by the reader in the same cycle is not yet usable.
    always_comb begin
        wstate_n = wstate;
        wcnt_n   = wcnt;
        wsel_n   = wsel;
        we       = 1'b0;
        waddr    = '0;
        full_set = '0;
        ovr_set  = 1'b0;
        ferr_set = 1'b0;
        start    = 1'b0;
        if (in_valid) begin
            case (wstate)
                W_IDLE: start = in_first;
                W_FILL: begin
                    if (in_first) begin
                        ferr_set = 1'b1;
                        start    = 1'b1;
                    end else begin
                        we    = 1'b1;
                        waddr = bitrev(wcnt);
                        if (wcnt == LAST) begin
                            full_set[wsel] = 1'b1;
                            wsel_n         = ~wsel;
                            wcnt_n         = '0;
                            wstate_n       = W_IDLE;
                        end else begin
                            wcnt_n = wcnt + 1'b1;
                        end
                    end
                end
                W_DROP: begin
                    if (in_first) begin
                        ferr_set = 1'b1;
                        start    = 1'b1;
                    end else if (wcnt == LAST) begin
                        wcnt_n   = '0;
                        wstate_n = W_IDLE;
                    end else begin
                        wcnt_n = wcnt + 1'b1;
                    end
                end
                default: wstate_n = W_IDLE;
            endcase
            // A restart in W_FILL targets the buffer being filled, which is never full.
            if (start) begin
                wcnt_n = LOG2N'(1);
                if (!full[wsel]) begin
                    we       = 1'b1;
                    waddr    = '0;
                    wstate_n = W_FILL;
                end else begin
                    ovr_set  = 1'b1;
                    wstate_n = W_DROP;
                end
            end
        end
    end

    always_comb begin
        rstate_n  = rstate;
        rcnt_n    = rcnt;
        rsel_n    = rsel;
        full_clr  = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        rd_last   = (rcnt == LAST);
        case (rstate)
            R_IDLE: begin
                if (full[rsel]) begin
                    rstate_n = R_DRAIN;
                    rcnt_n   = '0;
                end
            end
            R_DRAIN: begin
                out_valid = 1'b1;
                out_data  = rsel ? buf1[rcnt] : buf0[rcnt];
                out_last  = rd_last;
                if (out_ready) begin
                    if (rd_last) begin
                        full_clr[rsel] = 1'b1;
                        rsel_n         = ~rsel;
                        rcnt_n         = '0;
                        rstate_n       = R_IDLE;
                    end else begin
                        rcnt_n = rcnt + 1'b1;
                    end
                end
            end
            default: rstate_n = R_IDLE;
        endcase
    end

`ifdef FFT_REORDER_INDEX_EN
    assign out_index = rcnt;
`endif

    // Set and clear always target different buffers, so their order is moot.
    assign full_n      = (full | full_set) & ~full_clr;
    assign overrun_n   = ovr_set | (overrun & ~clr_status);
    assign frame_err_n = ferr_set | (frame_err & ~clr_status);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wstate    <= W_IDLE;
            rstate    <= R_IDLE;
            full      <= '0;
            wsel      <= 1'b0;
            rsel      <= 1'b0;
            wcnt      <= '0;
            rcnt      <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            wstate    <= wstate_n;
            rstate    <= rstate_n;
            full      <= full_n;
            wsel      <= wsel_n;
            rsel      <= rsel_n;
            wcnt      <= wcnt_n;
            rcnt      <= rcnt_n;
            overrun   <= overrun_n;
            frame_err <= frame_err_n;
        end
    end

    always_ff @(posedge clk) begin
        if (nrst && we) begin
            if (wsel) buf1[waddr] <= sample;
            else      buf0[waddr] <= sample;
        end
    end

endmodule

// File: tb/tb_fft_output_reorder.sv
// Directed bench for fft_output_reorder: vector table for one frame, then
// hand-written sequences for backpressure, ping-pong overrun, restart and reset.
module tb_fft_output_reorder;

    localparam int DW = 16;
    localparam int LOG2N = 6;
    localparam int N = 64;

    logic              clk = 1'b0;
    logic              nrst;
    logic              in_valid, in_first, bank_sel;
    logic [2*DW-1:0]   rdata_b0, rdata_b1;
    logic              out_ready;
    logic              out_valid;
    logic [2*DW-1:0]   out_data;
    logic              out_last;
`ifdef FFT_REORDER_INDEX_EN
    logic [LOG2N-1:0]  out_index;
`endif
    logic              overrun, frame_err, clr_status;

    int n_cmp = 0;
    int n_bad = 0;

    fft_output_reorder #(.DW(DW), .LOG2N(LOG2N), .N(N)) dut (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_first(in_first),
        .bank_sel(bank_sel), .rdata_b0(rdata_b0), .rdata_b1(rdata_b1),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last),
`ifdef FFT_REORDER_INDEX_EN
        .out_index(out_index),
`endif
        .overrun(overrun), .frame_err(frame_err), .clr_status(clr_status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] in_data;
        logic        in_bs;
        logic [31:0] exp_data;
        logic        exp_last;
    } vec_t;
    vec_t tbl[N];

    function automatic logic [5:0] br(input int k);
        logic [5:0] v, r;
        v = 6'(k);
        for (int i = 0; i < 6; i++) r[i] = v[5-i];
        return r;
    endfunction

    // Input sample k of a frame: re = {tag, 00, bitrev(k)}, im = k.
    function automatic logic [31:0] sdata(input int tag, input int k);
        return {8'(tag), 2'b00, br(k), 10'b0, 6'(k)};
    endfunction

    // Natural-order output j: re = {tag, 00, j}, im = bitrev(j).
    function automatic logic [31:0] edata(input int tag, input int j);
        return {8'(tag), 2'b00, 6'(j), 10'b0, br(j)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] d, input logic first, input logic bs);
        in_valid = 1'b1;
        in_first = first;
        bank_sel = bs;
        rdata_b0 = bs ? ~d : d;
        rdata_b1 = bs ? d : ~d;
        tick();
    endtask

    task automatic send_frame(input int tag, input int n);
        for (int k = 0; k < n; k++) drive(sdata(tag, k), k == 0, 1'((k + tag) % 2));
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    // Accept nhs outputs; frames follow tag0, tag0+1, ... Toggle gives 1/0 ready.
    task automatic drain(input int tag0, input int nhs, input bit toggle, input string nm);
        int j = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [31:0] held = '0;
        while (j < nhs && cyc < 2000) begin
            out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (out_valid) begin
                if (stalled) check({nm, " hold"}, 64'(out_data), 64'(held));
                if (out_ready) begin
                    check(nm, {31'b0, out_last, out_data},
                          {31'b0, (j % N) == N - 1, edata(tag0 + j / N, j % N)});
`ifdef FFT_REORDER_INDEX_EN
                    check({nm, " index"}, 64'(out_index), 64'(j % N));
`endif
                    j++;
                    stalled = 0;
                end else begin
                    held = out_data;
                    stalled = 1;
                end
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        if (j < nhs) check({nm, " timeout handshakes"}, 64'(j), 64'(nhs));
    endtask

    initial begin
        nrst = 1'b0; in_valid = 1'b0; in_first = 1'b0; bank_sel = 1'b0;
        rdata_b0 = '0; rdata_b1 = '0; out_ready = 1'b0; clr_status = 1'b0;
        for (int i = 0; i < N; i++) begin
            tbl[i].in_data  = sdata(1, i);
            tbl[i].in_bs    = 1'(i % 2);
            tbl[i].exp_data = edata(1, i);
            tbl[i].exp_last = (i == N - 1);
        end
        tick(); tick();
        check("reset out_valid", 64'(out_valid), 64'(0));
        check("reset out_last", 64'(out_last), 64'(0));
        check("reset out_data", 64'(out_data), 64'(0));
        check("reset flags", {62'b0, overrun, frame_err}, 64'(0));
        nrst = 1'b1;
        tick();

        // Single frame from the vector table
        for (int k = 0; k < N; k++) drive(tbl[k].in_data, k == 0, tbl[k].in_bs);
        idle_in();
        check("latency edge+1", 64'(out_valid), 64'(0));
        tick();
        check("latency edge+2", 64'(out_valid), 64'(1));
        out_ready = 1'b1;
        for (int j = 0; j < N; j++) begin
            check("single frame", {31'b0, out_valid, out_last, out_data},
                  {31'b0, 1'b1, tbl[j].exp_last, tbl[j].exp_data});
`ifdef FFT_REORDER_INDEX_EN
            check("index vs re", 64'(out_index), 64'(tbl[j].exp_data[21:16]));
`endif
            tick();
        end
        out_ready = 1'b0;
        check("single frame done", 64'(out_valid), 64'(0));

        // Backpressure
        send_frame(2, N);
        idle_in();
        drain(2, N, 1, "backpressure");
        tick();
        check("backpressure done", 64'(out_valid), 64'(0));

        // Ping-pong: two frames stored, third dropped
        send_frame(3, N);
        send_frame(4, N);
        send_frame(5, N);
        idle_in();
        check("overrun set", {62'b0, overrun, frame_err}, 64'h2);
        drain(3, 2 * N, 0, "pingpong");
        tick(); tick(); tick();
        check("no third frame", 64'(out_valid), 64'(0));
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        check("overrun cleared", 64'(overrun), 64'(0));

        // Mid-frame restart at sample 20
        send_frame(6, 20);
        send_frame(7, N);
        idle_in();
        check("frame_err set", {62'b0, overrun, frame_err}, 64'h1);
        drain(7, N, 0, "restart");
        tick(); tick(); tick();
        check("restart single frame", 64'(out_valid), 64'(0));
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        check("frame_err cleared", 64'(frame_err), 64'(0));

        // Reset while draining at natural index 30
        send_frame(8, 5);
        send_frame(9, N);
        idle_in();
        check("frame_err before reset", 64'(frame_err), 64'(1));
        drain(9, 30, 0, "pre-reset");
        check("at index 30", 64'(out_data), 64'(edata(9, 30)));
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        check("post-reset outputs", {30'b0, out_valid, out_last, overrun, frame_err, out_data},
              64'(0));
        tick(); tick(); tick();
        check("post-reset full cleared", 64'(out_valid), 64'(0));
        send_frame(10, N);
        idle_in();
        drain(10, N, 1, "post-reset frame");
        tick();
        check("post-reset done", 64'(out_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
